// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and helpers for the LOOK elevator scheduler
//
// Purpose: scheduler FSM states, LOOK direction encoding and an index-width
// helper shared by the scheduler top and its floor search sub-module.
// Ports: none (package).

package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ARRIVE
  } sched_state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_e;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int floor_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_floor_search.sv
// rtl/elevator_floor_search.sv - nearest pending floor above/below/at the car
//
// Purpose: purely combinational scan of the pending-request map relative to
// the current car floor.
// Ports:
//   pending    in  FLOORS_NUM  pending-request map, bit i = floor i
//   curr_floor in  FLOOR_W     current car floor
//   here       out 1           pending[curr_floor] is set
//   above_vld  out 1           some pending floor lies above the car
//   above_idx  out FLOOR_W     lowest pending floor above the car
//   below_vld  out 1           some pending floor lies below the car
//   below_idx  out FLOOR_W     highest pending floor below the car

module elevator_floor_search
  import elevator_pkg::*;
#(
  parameter  int FLOORS_NUM = 5,
  localparam int FLOOR_W    = floor_w(FLOORS_NUM)
) (
  input  logic [FLOORS_NUM-1:0] pending,
  input  logic [FLOOR_W-1:0]    curr_floor,
  output logic                  here,
  output logic                  above_vld,
  output logic [FLOOR_W-1:0]    above_idx,
  output logic                  below_vld,
  output logic [FLOOR_W-1:0]    below_idx
);

  always_comb begin
    here      = 1'b0;
    above_vld = 1'b0;
    above_idx = '0;
    below_vld = 1'b0;
    below_idx = '0;
    // Ascending scan: the last hit below the car is the highest one.
    for (int i = 0; i < FLOORS_NUM; i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) == curr_floor) begin
          here = 1'b1;
        end
        if (FLOOR_W'(i) < curr_floor) begin
          below_vld = 1'b1;
          below_idx = FLOOR_W'(i);
        end
      end
    end
    // Descending scan: the last hit above the car is the lowest one.
    for (int i = FLOORS_NUM - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > curr_floor)) begin
        above_vld = 1'b1;
        above_idx = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/elevator_look_scheduler.sv
// rtl/elevator_look_scheduler.sv - LOOK-policy target scheduler for one elevator car
//
// Purpose: latches cabin and hall requests into a pending map, picks the next
// target floor with a non-preemptive LOOK policy, hands it to the motion unit
// over a valid/ready handshake, retires it on arrival and optionally parks the
// idle car at HOME_FLOOR.
// Ports:
//   clk        in  1           system clock, rising edge
//   rst_n      in  1           asynchronous active-low reset
//   stop       in  1           emergency stop, flushes requests and target
//   req_int    in  FLOORS_NUM  cabin button pulses
//   req_ext    in  FLOORS_NUM  hall button pulses
//   curr_floor in  FLOOR_W     current car floor
//   arrived    in  1           car stopped at the accepted target
//   tgt_ready  in  1           motion unit can accept a target
//   tgt_valid  out 1           tgt_floor is valid
//   tgt_floor  out FLOOR_W     target floor
//   pending    out FLOORS_NUM  registered pending-request map
//   dir_up     out 1           LOOK direction is up
//   dir_dn     out 1           LOOK direction is down

module elevator_look_scheduler
  import elevator_pkg::*;
#(
  parameter  int FLOORS_NUM       = 5,
  parameter  int HOME_FLOOR       = 0,
  parameter  int IDLE_HOME_CYCLES = 8,
  localparam int FLOOR_W          = floor_w(FLOORS_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stop,
  input  logic [FLOORS_NUM-1:0] req_int,
  input  logic [FLOORS_NUM-1:0] req_ext,
  input  logic [FLOOR_W-1:0]    curr_floor,
  input  logic                  arrived,
  input  logic                  tgt_ready,
  output logic                  tgt_valid,
  output logic [FLOOR_W-1:0]    tgt_floor,
  output logic [FLOORS_NUM-1:0] pending,
  output logic                  dir_up,
  output logic                  dir_dn
);

  localparam int                 CNT_W      = floor_w(IDLE_HOME_CYCLES + 1);
  localparam logic [FLOOR_W-1:0] HOME_IDX   = FLOOR_W'(HOME_FLOOR);
  localparam logic [CNT_W-1:0]   HOME_LIMIT = CNT_W'(IDLE_HOME_CYCLES);

  sched_state_e          state_q, state_nxt;
  dir_e                  dir_q, dir_nxt;
  logic [CNT_W-1:0]      home_cnt_q, home_cnt_nxt;
  logic                  home_trip_q, home_trip_nxt;
  logic                  tgt_valid_nxt;
  logic [FLOOR_W-1:0]    tgt_floor_nxt;
  logic [FLOORS_NUM-1:0] pending_nxt;
  logic [FLOORS_NUM-1:0] clr_mask;
  logic                  floor_ok;
  logic                  arrive_ack;

  logic                  here;
  logic                  above_vld;
  logic                  below_vld;
  logic [FLOOR_W-1:0]    above_idx;
  logic [FLOOR_W-1:0]    below_idx;

  elevator_floor_search #(
    .FLOORS_NUM (FLOORS_NUM)
  ) u_search (
    .pending    (pending),
    .curr_floor (curr_floor),
    .here       (here),
    .above_vld  (above_vld),
    .above_idx  (above_idx),
    .below_vld  (below_vld),
    .below_idx  (below_idx)
  );

  // An out-of-range position report from the motion unit blocks all issuing.
  assign floor_ok   = int'(curr_floor) < FLOORS_NUM;
  assign arrive_ack = (state_q == WAIT_ARRIVE) && arrived && !stop;

  // A home trip never retires a request; it was not served from the map.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < FLOORS_NUM; i++) begin
      clr_mask[i] = arrive_ack && !home_trip_q && (tgt_floor == FLOOR_W'(i));
    end
  end

  // The clear mask is applied after the OR so it beats a same-cycle request.
  assign pending_nxt = stop ? '0 : ((pending | req_int | req_ext) & ~clr_mask);

  always_comb begin
    state_nxt     = state_q;
    dir_nxt       = dir_q;
    tgt_valid_nxt = tgt_valid;
    tgt_floor_nxt = tgt_floor;
    home_trip_nxt = home_trip_q;
    home_cnt_nxt  = '0;

    if (stop) begin
      state_nxt     = IDLE;
      dir_nxt       = DIR_NONE;
      tgt_valid_nxt = 1'b0;
      tgt_floor_nxt = '0;
      home_trip_nxt = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending != '0) begin
            if (floor_ok) begin
              state_nxt     = ISSUE;
              tgt_valid_nxt = 1'b1;
              home_trip_nxt = 1'b0;
              if (here) begin
                tgt_floor_nxt = curr_floor;
              end else begin
                case (dir_q)
                  DIR_UP: begin
                    if (above_vld) begin
                      tgt_floor_nxt = above_idx;
                    end else begin
                      tgt_floor_nxt = below_idx;
                      dir_nxt       = DIR_DN;
                    end
                  end
                  DIR_DN: begin
                    if (below_vld) begin
                      tgt_floor_nxt = below_idx;
                    end else begin
                      tgt_floor_nxt = above_idx;
                      dir_nxt       = DIR_UP;
                    end
                  end
                  default: begin
                    if (above_vld) begin
                      tgt_floor_nxt = above_idx;
                      dir_nxt       = DIR_UP;
                    end else begin
                      tgt_floor_nxt = below_idx;
                      dir_nxt       = DIR_DN;
                    end
                  end
                endcase
              end
            end
          end else begin
            dir_nxt = DIR_NONE;
            if ((IDLE_HOME_CYCLES != 0) && floor_ok && (curr_floor != HOME_IDX)) begin
              if (home_cnt_q >= HOME_LIMIT) begin
                state_nxt     = ISSUE;
                tgt_valid_nxt = 1'b1;
                tgt_floor_nxt = HOME_IDX;
                home_trip_nxt = 1'b1;
                dir_nxt       = (curr_floor > HOME_IDX) ? DIR_DN : DIR_UP;
              end else begin
                home_cnt_nxt = home_cnt_q + CNT_W'(1);
              end
            end
          end
        end

        ISSUE: begin
          if (tgt_ready) begin
            tgt_valid_nxt = 1'b0;
            state_nxt     = WAIT_ARRIVE;
          end
        end

        WAIT_ARRIVE: begin
          if (arrived) begin
            state_nxt     = IDLE;
            home_trip_nxt = 1'b0;
          end
        end

        default: begin
          state_nxt     = IDLE;
          tgt_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= DIR_NONE;
      home_cnt_q  <= '0;
      home_trip_q <= 1'b0;
      tgt_valid   <= 1'b0;
      tgt_floor   <= '0;
      pending     <= '0;
    end else begin
      state_q     <= state_nxt;
      dir_q       <= dir_nxt;
      home_cnt_q  <= home_cnt_nxt;
      home_trip_q <= home_trip_nxt;
      tgt_valid   <= tgt_valid_nxt;
      tgt_floor   <= tgt_floor_nxt;
      pending     <= pending_nxt;
    end
  end

  assign dir_up = (dir_q == DIR_UP);
  assign dir_dn = (dir_q == DIR_DN);

endmodule

// File: tb/tb_elevator_look_scheduler.sv
// tb/tb_elevator_look_scheduler.sv - directed self-checking bench for elevator_look_scheduler

module tb_elevator_look_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stop;
  logic [4:0] req_int;
  logic [4:0] req_ext;
  logic [2:0] curr_floor;
  logic       arrived;
  logic       tgt_ready;
  logic       tgt_valid;
  logic [2:0] tgt_floor;
  logic [4:0] pending;
  logic       dir_up;
  logic       dir_dn;

  int total = 0;
  int bad   = 0;

  elevator_look_scheduler #(
    .FLOORS_NUM       (5),
    .HOME_FLOOR       (0),
    .IDLE_HOME_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stop       (stop),
    .req_int    (req_int),
    .req_ext    (req_ext),
    .curr_floor (curr_floor),
    .arrived    (arrived),
    .tgt_ready  (tgt_ready),
    .tgt_valid  (tgt_valid),
    .tgt_floor  (tgt_floor),
    .pending    (pending),
    .dir_up     (dir_up),
    .dir_dn     (dir_dn)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [4:0] ri, input logic [4:0] re);
    req_int = ri;
    req_ext = re;
    step();
    req_int = '0;
    req_ext = '0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      if (tgt_valid === 1'b1) ok = 1'b1;
      else step();
    end
  endtask

  task automatic handshake();
    tgt_ready = 1'b1;
    step();
    tgt_ready = 1'b0;
  endtask

  task automatic arrive_at(input logic [2:0] f);
    curr_floor = f;
    step();
    arrived = 1'b1;
    step();
    arrived = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({tgt_valid, tgt_floor, pending, dir_up, dir_dn} !== 11'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b f=%0d p=%b up=%0b dn=%0b want all 0",
               tgt_valid, tgt_floor, pending, dir_up, dir_dn);
    end
    rst_n = 1'b1;
    step();
    pulse_req(5'b00100, 5'b00000);
    step();
    handshake();
    pulse_req(5'b01000, 5'b00000);
    total++;
    if (pending !== 5'b01100 || tgt_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_setup: got p=%b v=%0b want p=01100 v=0", pending, tgt_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({tgt_valid, pending, dir_up, dir_dn} !== 8'b0) begin
      bad++;
      $display("FAIL reset_async: got v=%0b p=%b up=%0b dn=%0b want all 0",
               tgt_valid, pending, dir_up, dir_dn);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    curr_floor = 3'd0;
    pulse_req(5'b00000, 5'b01010);
    total++;
    if (pending !== 5'b01010 || tgt_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_latch: got p=%b v=%0b want p=01010 v=0", pending, tgt_valid);
    end
    step();
    total++;
    if (tgt_valid !== 1'b1 || tgt_floor !== 3'd1 || dir_up !== 1'b1 || dir_dn !== 1'b0) begin
      bad++;
      $display("FAIL basic_first: got v=%0b f=%0d up=%0b dn=%0b want v=1 f=1 up=1 dn=0",
               tgt_valid, tgt_floor, dir_up, dir_dn);
    end
    handshake();
    total++;
    if (tgt_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_handshake: got v=%0b want 0", tgt_valid);
    end
    arrive_at(3'd1);
    total++;
    if (pending !== 5'b01000) begin
      bad++;
      $display("FAIL basic_clear1: got p=%b want 01000", pending);
    end
    wait_valid(10, ok);
    total++;
    if (!ok || tgt_floor !== 3'd3 || dir_up !== 1'b1) begin
      bad++;
      $display("FAIL basic_second: got ok=%0b f=%0d up=%0b want ok=1 f=3 up=1", ok, tgt_floor, dir_up);
    end
    handshake();
    arrive_at(3'd3);
    total++;
    if (pending !== 5'b00000) begin
      bad++;
      $display("FAIL basic_clear2: got p=%b want 00000", pending);
    end
    step();
    total++;
    if (dir_up !== 1'b0 || dir_dn !== 1'b0) begin
      bad++;
      $display("FAIL basic_dir_none: got up=%0b dn=%0b want 0 0", dir_up, dir_dn);
    end
    curr_floor = 3'd0;
    step();
  endtask

  task automatic test_look();
    bit ok;
    curr_floor = 3'd0;
    pulse_req(5'b00100, 5'b00000);
    step();
    total++;
    if (tgt_valid !== 1'b1 || tgt_floor !== 3'd2 || dir_up !== 1'b1) begin
      bad++;
      $display("FAIL look_first: got v=%0b f=%0d up=%0b want v=1 f=2 up=1", tgt_valid, tgt_floor, dir_up);
    end
    handshake();
    pulse_req(5'b00000, 5'b10001);
    arrive_at(3'd2);
    total++;
    if (pending !== 5'b10001) begin
      bad++;
      $display("FAIL look_pending: got p=%b want 10001", pending);
    end
    wait_valid(10, ok);
    total++;
    if (!ok || tgt_floor !== 3'd4 || dir_up !== 1'b1 || dir_dn !== 1'b0) begin
      bad++;
      $display("FAIL look_keep_up: got ok=%0b f=%0d up=%0b dn=%0b want ok=1 f=4 up=1 dn=0",
               ok, tgt_floor, dir_up, dir_dn);
    end
    handshake();
    arrive_at(3'd4);
    total++;
    if (pending !== 5'b00001) begin
      bad++;
      $display("FAIL look_clear4: got p=%b want 00001", pending);
    end
    wait_valid(10, ok);
    total++;
    if (!ok || tgt_floor !== 3'd0 || dir_up !== 1'b0 || dir_dn !== 1'b1) begin
      bad++;
      $display("FAIL look_reverse: got ok=%0b f=%0d up=%0b dn=%0b want ok=1 f=0 up=0 dn=1",
               ok, tgt_floor, dir_up, dir_dn);
    end
    handshake();
    arrive_at(3'd0);
    step();
    total++;
    if (pending !== 5'b00000 || dir_up !== 1'b0 || dir_dn !== 1'b0) begin
      bad++;
      $display("FAIL look_done: got p=%b up=%0b dn=%0b want p=00000 up=0 dn=0", pending, dir_up, dir_dn);
    end
  endtask

  task automatic test_stop();
    int seen;
    curr_floor = 3'd0;
    pulse_req(5'b00100, 5'b00000);
    step();
    total++;
    if (tgt_valid !== 1'b1) begin
      bad++;
      $display("FAIL stop_setup: got v=%0b want 1", tgt_valid);
    end
    stop    = 1'b1;
    req_int = 5'b00100;
    req_ext = 5'b00001;
    step();
    stop    = 1'b0;
    req_int = '0;
    req_ext = '0;
    total++;
    if (tgt_valid !== 1'b0 || pending !== 5'b00000 || dir_up !== 1'b0 || dir_dn !== 1'b0) begin
      bad++;
      $display("FAIL stop_flush: got v=%0b p=%b up=%0b dn=%0b want 0 00000 0 0",
               tgt_valid, pending, dir_up, dir_dn);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tgt_valid !== 1'b0 || pending !== 5'b00000) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL stop_quiet: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_arrive_clear();
    int unstable;
    curr_floor = 3'd0;
    pulse_req(5'b01000, 5'b00000);
    step();
    total++;
    if (tgt_valid !== 1'b1 || tgt_floor !== 3'd3) begin
      bad++;
      $display("FAIL hold_setup: got v=%0b f=%0d want v=1 f=3", tgt_valid, tgt_floor);
    end
    unstable = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (tgt_valid !== 1'b1 || tgt_floor !== 3'd3) unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable);
    end
    handshake();
    curr_floor = 3'd3;
    step();
    arrived = 1'b1;
    req_int = 5'b01000;
    step();
    arrived = 1'b0;
    req_int = '0;
    total++;
    if (pending !== 5'b00000) begin
      bad++;
      $display("FAIL clear_wins: got p=%b want 00000", pending);
    end
    step();
    total++;
    if (tgt_valid !== 1'b0) begin
      bad++;
      $display("FAIL clear_no_reissue: got v=%0b want 0", tgt_valid);
    end
    curr_floor = 3'd0;
    step();
  endtask

  task automatic test_invalid_floor();
    bit ok;
    int seen;
    curr_floor = 3'd6;
    pulse_req(5'b00000, 5'b00010);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (tgt_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || pending !== 5'b00010) begin
      bad++;
      $display("FAIL invalid_floor: got active=%0d p=%b want active=0 p=00010", seen, pending);
    end
    curr_floor = 3'd1;
    wait_valid(5, ok);
    total++;
    if (!ok || tgt_floor !== 3'd1 || dir_up !== 1'b0 || dir_dn !== 1'b0) begin
      bad++;
      $display("FAIL here_target: got ok=%0b f=%0d up=%0b dn=%0b want ok=1 f=1 up=0 dn=0",
               ok, tgt_floor, dir_up, dir_dn);
    end
    handshake();
    arrive_at(3'd1);
    total++;
    if (pending !== 5'b00000) begin
      bad++;
      $display("FAIL here_clear: got p=%b want 00000", pending);
    end
    curr_floor = 3'd0;
    step();
  endtask

  task automatic test_homing();
    bit ok;
    int seen;
    curr_floor = 3'd0;
    step();
    step();
    curr_floor = 3'd3;
    seen = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (tgt_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL home_early: got %0d early valid cycles want 0", seen);
    end
    wait_valid(4, ok);
    total++;
    if (!ok || tgt_floor !== 3'd0 || dir_dn !== 1'b1 || pending !== 5'b00000) begin
      bad++;
      $display("FAIL home_issue: got ok=%0b f=%0d dn=%0b p=%b want ok=1 f=0 dn=1 p=00000",
               ok, tgt_floor, dir_dn, pending);
    end
    handshake();
    arrive_at(3'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (tgt_valid !== 1'b0 || pending !== 5'b00000) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL home_parked: got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    stop       = 1'b0;
    req_int    = '0;
    req_ext    = '0;
    curr_floor = 3'd0;
    arrived    = 1'b0;
    tgt_ready  = 1'b0;
    test_reset();
    test_basic();
    test_look();
    test_stop();
    test_arrive_clear();
    test_invalid_floor();
    test_homing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
